// File: rtl/xor_acc_n2t.sv
// ============================================================================
// Module   : xor_acc_n2t
// Brief    : Streaming frame XOR accumulator. Emits XOR word, parity and
//            saturating beat count per frame. Optional out_err via
//            XOR_ACC_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_acc_n2t #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 255,
  localparam int CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CW-1:0]    out_count
`ifdef XOR_ACC_ERR_EN
  ,
  output logic             out_err
`endif
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_cnt_full;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_accept   = in_valid & in_ready & (r_state == ST_ACCUM);
  assign w_cnt_full = (r_cnt == CNT_MAX);
  assign w_acc_nxt  = r_acc ^ in_data;
  assign w_cnt_nxt  = w_cnt_full ? r_cnt : r_cnt + 1'b1;

  // in_ready is held low for the first cycle out of reset, then follows state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          in_ready <= 1'b1;
          if (w_accept) begin
            if (in_last) begin
              out_data   <= w_acc_nxt;
              out_parity <= ^w_acc_nxt;
              out_count  <= w_cnt_nxt;
              r_acc      <= '0;
              r_cnt      <= '0;
              out_valid  <= 1'b1;
              in_ready   <= 1'b0;
              r_state    <= ST_DONE;
            end else begin
              r_acc <= w_acc_nxt;
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_ACCUM;
          end
        end
        default: begin
          r_state   <= ST_ACCUM;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

`ifdef XOR_ACC_ERR_EN
  logic r_ovf;

  // Sticky overflow: any beat arriving once the counter has saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      out_err <= 1'b0;
    end else if (w_accept) begin
      if (in_last) begin
        out_err <= r_ovf | w_cnt_full;
        r_ovf   <= 1'b0;
      end else if (w_cnt_full) begin
        r_ovf <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
